// File: rtl/arithmetic_mul_seq.sv
// -----------------------------------------------------------------------------
// arithmetic_mul_seq
//
// Sequential signed multiplier using Booth recoding. The 2*WIDTH product uses
// the same {HI, LO} layout as the datapath divider, so it can be written
// straight into the HI/LO registers.
//
// Build option:
//   MUL_BIT_PAIR_EN  - when defined, radix-4 (bit-pair) recoding retires two
//                      multiplier bits per clock (WIDTH/2 steps). When left
//                      undefined, radix-2 Booth retires one bit per clock
//                      (WIDTH steps).
//
// Parameters:
//   WIDTH   operand width in bits (even, >= 4); product is 2*WIDTH bits
//
// Ports:
//   clock    in   rising-edge clock
//   clear_n  in   asynchronous active-low reset; abandons any operation
//   start    in   operation request, sampled only while idle
//   in_a     in   multiplicand M, two's complement, latched on accepted start
//   in_b     in   multiplier Q, two's complement, latched on accepted start
//   busy     out  high while an operation is running or completing
//   done     out  one-cycle pulse, result valid
//   result   out  signed product {HI, LO}; held until the next completion
// -----------------------------------------------------------------------------
module arithmetic_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

`ifdef MUL_BIT_PAIR_EN
    // Two guard bits so that A +/- 2M cannot wrap.
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = WIDTH / 2;
`else
    // One guard bit covers M = -2^(WIDTH-1).
    localparam int AW    = WIDTH + 1;
    localparam int STEPS = WIDTH;
`endif
    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state, state_nxt;

    // Control strobes decoded from the state.
    logic load;
    logic step;
    logic finish;

    // Datapath registers.
    logic signed [WIDTH:0]   m_reg;
    logic signed [AW-1:0]    acc;
    logic [WIDTH-1:0]        q_reg;
    logic                    q_m1;
    logic [CW-1:0]           cnt;

    // Next-step values.
    logic signed [AW-1:0]    m_ext;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    acc_nxt;
    logic [WIDTH-1:0]        q_nxt;
    logic                    q_m1_nxt;
    logic [2*WIDTH-1:0]      prod_nxt;

    // -------------------------------------------------------------------------
    // Booth add/subtract selection
    // -------------------------------------------------------------------------
    // Radix-2: {Q[0], q-1} selects 0, +M or -M.
    function automatic logic signed [AW-1:0] booth_r2(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] m,
        input logic [1:0]           sel
    );
        case (sel)
            2'b01:   return a + m;
            2'b10:   return a - m;
            default: return a;
        endcase
    endfunction

    // Radix-4: {Q[1], Q[0], q-1} selects 0, +/-M or +/-2M.
    function automatic logic signed [AW-1:0] booth_r4(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] m,
        input logic [2:0]           sel
    );
        logic signed [AW-1:0] m2;
        m2 = {m[AW-2:0], 1'b0};
        case (sel)
            3'b001, 3'b010: return a + m;
            3'b011:         return a + m2;
            3'b100:         return a - m2;
            3'b101, 3'b110: return a - m;
            default:        return a;
        endcase
    endfunction

`ifdef MUL_BIT_PAIR_EN
    assign m_ext    = {m_reg[WIDTH], m_reg};
    assign sum      = booth_r4(acc, m_ext, {q_reg[1:0], q_m1});
    // Arithmetic shift of {A, Q, q-1} right by two.
    assign acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_nxt    = {sum[1:0], q_reg[WIDTH-1:2]};
    assign q_m1_nxt = q_reg[1];
`else
    assign m_ext    = m_reg;
    assign sum      = booth_r2(acc, m_ext, {q_reg[0], q_m1});
    // Arithmetic shift of {A, Q, q-1} right by one.
    assign acc_nxt  = {sum[AW-1], sum[AW-1:1]};
    assign q_nxt    = {sum[0], q_reg[WIDTH-1:1]};
    assign q_m1_nxt = q_reg[0];
`endif

    // After the last step the low 2*WIDTH bits of {A, Q} hold the exact
    // product; the guard bits above are only sign copies.
    assign prod_nxt = {acc_nxt[WIDTH-1:0], q_nxt};

    // -------------------------------------------------------------------------
    // Control FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            m_reg <= {in_a[WIDTH-1], in_a};
            acc   <= '0;
            q_reg <= in_b;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            q_reg <= q_nxt;
            q_m1  <= q_m1_nxt;
            cnt   <= cnt + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Result register: updated only on completion, so a new start leaves the
    // previous product visible until the next one is ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            result <= '0;
        end else if (finish) begin
            result <= prod_nxt;
        end
    end

endmodule

// File: tb/tb_arithmetic_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_arithmetic_mul_seq
//
// Directed and randomized checks of arithmetic_mul_seq (WIDTH = 32). Expected
// products are queued when an operation is started and popped when done
// pulses. Latency follows MUL_BIT_PAIR_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_arithmetic_mul_seq;

    localparam int W = 32;
`ifdef MUL_BIT_PAIR_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam int LIMIT = STEPS + 10;

    logic               clock;
    logic               clear_n;
    logic               start;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     result;

    int tests;
    int fails;
    logic [2*W-1:0] exp_q[$];

    arithmetic_mul_seq #(.WIDTH(W)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (start),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result();
        logic [2*W-1:0] exp;
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check("result", result, exp);
        end
    endtask

    // Waits at negedges until done, counting edges since the start edge.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < LIMIT) begin
            check("busy_run", busy, 1);
            @(negedge clock);
            lat++;
        end
        check("done_seen", done, 1);
        check("busy_done", busy, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int lat;
        @(negedge clock);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clock);
        start = 1'b0;
        in_a  = ~a;
        in_b  = ~b;
        wait_done(0, lat);
        check("latency", 64'(lat), 64'(STEPS));
        check_result();
        @(negedge clock);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        tests   = 0;
        fails   = 0;
        clear_n = 1'b0;
        start   = 1'b0;
        in_a    = '0;
        in_b    = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        clear_n = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 0);

        // Directed products
        run_op(32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_op(32'h1234_5678, 32'd0,         64'h0);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // Start while busy is ignored
        @(negedge clock);
        in_a  = 32'd6;
        in_b  = 32'd7;
        start = 1'b1;
        exp_q.push_back(64'd42);
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        repeat (4) begin
            check("busy_run", busy, 1);
            @(negedge clock);
            lat++;
        end
        in_a  = 32'd3;
        in_b  = 32'd3;
        start = 1'b1;
        @(negedge clock);
        lat++;
        start = 1'b0;
        wait_done(lat, lat);
        check("ignored_latency", 64'(lat), 64'(STEPS));
        check_result();
        repeat (STEPS + 4) begin
            @(negedge clock);
            check("no_second_done", done, 0);
            check("no_second_busy", busy, 0);
        end
        check("result_hold", result, 64'd42);

        // Asynchronous reset mid-operation
        @(negedge clock);
        in_a  = 32'd100;
        in_b  = 32'd200;
        start = 1'b1;
        exp_q.push_back(64'd20000);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        #2;
        clear_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_result", result, 0);
        exp_q.delete();
        @(negedge clock);
        clear_n = 1'b1;
        repeat (STEPS + 4) begin
            @(negedge clock);
            check("abandoned_no_done", done, 0);
        end
        run_op(32'd5, 32'd5, 64'd25);

        // Start held high: one operation every STEPS+2 cycles
        @(negedge clock);
        in_a  = 32'd2;
        in_b  = 32'd3;
        start = 1'b1;
        exp_q.push_back(64'd6);
        @(negedge clock);
        in_a  = 32'd4;
        in_b  = 32'd5;
        exp_q.push_back(64'd20);
        wait_done(0, lat);
        check("cont_latency_1", 64'(lat), 64'(STEPS));
        check_result();
        @(negedge clock);
        check("cont_idle_gap", busy, 0);
        @(negedge clock);
        start = 1'b0;
        wait_done(0, lat);
        check("cont_period", 64'(lat + 2), 64'(STEPS + 2));
        check_result();
        @(negedge clock);
        check("cont_busy_after", busy, 0);

        // Randomized signed pairs with extreme values mixed in
        for (int i = 0; i < 1000; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(ra, rb, ref_mul(ra, rb));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arithmetic_mul_seq.md
Name: arithmetic_mul_seq

Overview:
- Sequential signed multiplier; the inverse operation of the datapath divider.
- Produces a 2*WIDTH product, laid out exactly as the divider result: result[2W-1:W] = HI, result[W-1:0] = LO. The product feeds the HI/LO registers of the ALU datapath.
- Radix-2 Booth recoding, one recoding step per clock.
- Start/busy/done handshake lets the control unit stall until the product is ready.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4. Product is 2*WIDTH bits.

Ports:
- clock  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in_a  input  WIDTH  multiplicand M, two's complement
- in_b  input  WIDTH  multiplier Q, two's complement
- busy  output  1  high while an operation is in progress (RUN or DONE)
- done  output  1  one-cycle pulse; result valid
- result  output  2*WIDTH  signed product {HI, LO}

Behaviour:
- Reset (clear_n=0, asynchronous, any state):
  - state=IDLE, busy=0, done=0, result=0, iteration counter=0.
  - Internal A/Q/q-1/M registers cleared.
  - An operation in flight is abandoned and no done is issued.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended in_a.
  - A: WIDTH+1 bits, accumulator.
  - Q: WIDTH bits.
  - q-1: 1 bit.
  - cnt: log2(WIDTH)+1 bits.
- IDLE:
  - busy=0.
  - On start=1 at a rising edge: latch M=sext(in_a), Q=in_b, A=0, q-1=0, cnt=0; go to RUN.
  - in_a/in_b may change after the latching edge without effect.
- RUN: each edge, examine {Q[0], q-1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,q-1} by 1; A keeps its sign bit.
  - cnt increments each step. After the WIDTH-th step go to DONE.
  - All arithmetic is modulo 2^(WIDTH+1). The extra A bit prevents overflow for M = -2^(WIDTH-1).
- DONE (one cycle):
  - done=1, busy=1.
  - result={A[WIDTH-1:0], Q} is registered on the edge entering DONE.
  - Next edge: go to IDLE, done=0.
- Result hold: result holds its value until the edge that completes the next operation. It is not cleared by start.
- Latency:
  - start sampled at edge k.
  - busy=1 from edge k to edge k+WIDTH+1.
  - done=1 in the cycle after edge k+WIDTH (33 cycles after start for WIDTH=32).
  - A back-to-back start is accepted earliest at edge k+WIDTH+2 (IDLE).
- start while busy=1 is ignored and is not queued.
- start held high continuously: a new operation begins every WIDTH+2 cycles.
- Overflow: none possible. Full 2W-bit product is exact for all operand pairs, including (-2^(W-1))*(-2^(W-1)).

Optional Feature:
- MUL_BIT_PAIR_EN defined:
  - Radix-4 bit-pair recoding. Examine {Q[1],Q[0],q-1} and add 0, ±M or ±2M.
  - A widened to WIDTH+2 bits; arithmetic right shift by 2 per step.
  - WIDTH/2 steps, so done arrives in the cycle after edge k+WIDTH/2 (17 cycles for WIDTH=32).
  - Handshake, result format and reset behaviour unchanged.
- Undefined: radix-2 as described above.
- Bench reads latency from the same macro.

Test Plan:
- in_a=7, in_b=-3 (0xFFFFFFFD), pulse start -> done after 33 cycles, result=0xFFFFFFFF_FFFFFFEB; busy high throughout.
- in_a=0x80000000, in_b=0x80000000 -> result=0x40000000_00000000; in_a=0x80000000, in_b=1 -> result=0xFFFFFFFF_80000000.
- in_a=-1, in_b=-1 -> result=0x00000000_00000001; in_a=0x12345678, in_b=0 -> result=0; in_a=0x7FFFFFFF, in_b=0x7FFFFFFF -> 0x3FFFFFFF_00000001.
- Start 6*7; assert start again with 3*3 at cycle 5 -> ignored; done once with result=42; next start accepted only after idle.
- Start 100*200; drop clear_n at cycle 10 asynchronously -> busy/done/result=0 immediately; after release, 5*5 -> result=25 with normal latency.
- Randomized 1000 signed pairs, including the extreme values 0x80000000, 0x7FFFFFFF and 0 -> result equals the 64-bit signed reference product. Run both with and without MUL_BIT_PAIR_EN and check the latency for each.
